// File: rtl/bus_master.sv
// Bus master: turns single core load/store requests into arbitrated bus tenures.
// Optional grant-wait timeout is enabled by defining BUSMST_TIMEOUT_EN.
module bus_master #(
    parameter int WIDTH   = 32,
    parameter int MEM_LAT = 1,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_adr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             req_ack,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             err,
    output logic             breq_,
    input  logic             bgrt_,
    output logic             own,
    output logic [WIDTH-1:0] adr,
    output logic             rw_,
    output logic [WIDTH-1:0] idata,
    input  logic [WIDTH-1:0] odata,
    output logic             done
);

    if (MEM_LAT < 1 || MEM_LAT > 15 || TIMEOUT < 1) begin : g_param_check
        $error("bus_master: MEM_LAT must be 1..15 and TIMEOUT at least 1");
    end

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_WAIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   adr_q, adr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   rdata_q, rdata_d;
    logic               breq_q, own_q, done_q, ack_q, busy_q, err_q;
    logic               tmo_expired;
    logic               on_bus;
    logic               wr_phase;

`ifdef BUSMST_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counter idles at zero outside REQ, so every entry to REQ starts a fresh wait.
    assign tmo_d       = (state_q == S_REQ) ? tmo_q + 1'b1 : '0;
    assign tmo_expired = (state_q == S_REQ) && bgrt_ && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`else
    assign tmo_expired = 1'b0;
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = req_we;
                    adr_d   = req_adr;
                    wdata_d = req_wdata;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!bgrt_)           state_d = S_XFER;
                else if (tmo_expired) state_d = S_IDLE;
            end
            S_XFER: begin
                if (bgrt_) begin
                    state_d = S_REQ;
                end else if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Losing the grant takes priority over a capture in the same cycle.
                if (bgrt_) begin
                    state_d = S_REQ;
                end else if (cnt_q == 4'd0) begin
                    rdata_d = odata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            breq_q  <= 1'b1;
            own_q   <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            breq_q  <= (state_d == S_IDLE);
            own_q   <= (state_d inside {S_XFER, S_WAIT, S_DONE});
            done_q  <= (state_d == S_DONE);
            ack_q   <= (state_d == S_DONE) || tmo_expired;
            busy_q  <= (state_d != S_IDLE);
            err_q   <= tmo_expired;
        end
    end

    // NOTE: operand registers are not reset; they only reach the bus through state-gated decode.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        adr_q   <= adr_d;
        wdata_q <= wdata_d;
    end

    assign on_bus   = (state_q == S_XFER) || (state_q == S_WAIT) || (state_q == S_DONE);
    assign wr_phase = (state_q == S_XFER) && we_q;
    assign adr      = on_bus ? adr_q : '0;
    assign rw_      = ~wr_phase;
    assign idata    = wr_phase ? wdata_q : '0;

    assign breq_   = breq_q;
    assign own     = own_q;
    assign done    = done_q;
    assign req_ack = ack_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed self-checking bench for bus_master (default parameters, MEM_LAT=1).
// Covers the timeout path as well when compiled with BUSMST_TIMEOUT_EN.
module tb_bus_master;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, req, req_we, bgrt_;
    logic [W-1:0] req_adr, req_wdata, odata;
    logic         req_ack, busy, err, breq_, own, rw_, done;
    logic [W-1:0] rdata, adr, idata;

    int n_checks = 0;
    int n_errors = 0;

    bus_master #(.WIDTH(W), .MEM_LAT(1), .TIMEOUT(64)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .req_ack   (req_ack),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .breq_     (breq_),
        .bgrt_     (bgrt_),
        .own       (own),
        .adr       (adr),
        .rw_       (rw_),
        .idata     (idata),
        .odata     (odata),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request in IDLE for a single edge; the DUT is in REQ afterwards.
    task automatic issue(input logic we, input logic [W-1:0] a, input logic [W-1:0] d);
        req       = 1'b1;
        req_we    = we;
        req_adr   = a;
        req_wdata = d;
        step();
        req = 1'b0;
    endtask

    task automatic run_acks(input int cycles, output int acks, output logic [W-1:0] ack_rdata);
        acks      = 0;
        ack_rdata = '0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (req_ack === 1'b1) begin
                acks++;
                ack_rdata = rdata;
            end
        end
    endtask

    // {breq_, own, done, req_ack, busy, err, rw_} at reset is 1,0,0,0,0,0,1.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"},  W'({breq_, own, done, req_ack, busy, err, rw_}), 'h41);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_adr"},   adr,   0);
        check({tag, "_idata"}, idata, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat, acks, bad;
        logic [W-1:0] ack_rd;

        reset = 1'b1; req = 1'b0; req_we = 1'b0; req_adr = '0; req_wdata = '0;
        bgrt_ = 1'b1; odata = '0;
        step(); step();
        check_reset_outputs("reset");
        reset = 1'b0;
        step();
        check("idle_after_reset", W'({breq_, busy, own}), 'h4);

        // Read adr 8, ack in the 3rd granted cycle (XFER, WAIT, DONE).
        odata = 32'hDEAD_BEEF;
        issue(1'b0, 32'd8, 32'd0);
        check("rd_req_breq_own", W'({breq_, own, busy}), 'h1);
        bgrt_ = 1'b0;
        step();
        lat = 1;
        check("rd_xfer_bus", W'({own, rw_}), 'h3);
        check("rd_xfer_adr", adr, 32'd8);
        check("rd_xfer_idata", idata, 0);
        while (req_ack !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("rd_latency", W'(lat), 3);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_done", W'({done, own, breq_}), 'h6);
        bgrt_ = 1'b1;
        step();
        check("rd_back_idle", W'({breq_, req_ack, own, done}), 'h8);

        // Write 0x14 to adr 5 with grant held low.
        bgrt_ = 1'b0;
        issue(1'b1, 32'd5, 32'h14);
        check("wr_req_breq", W'(breq_), 0);
        step();
        check("wr_xfer_own_rw", W'({own, rw_}), 'h2);
        check("wr_xfer_adr", adr, 32'd5);
        check("wr_xfer_idata", idata, 32'd20);
        step();
        check("wr_done", W'({done, req_ack, own, breq_, rw_}), 'h1D);
        check("wr_done_idata", idata, 0);
        step();
        check("wr_idle", W'({breq_, busy, done, req_ack, own}), 'h10);
        check("wr_idle_adr", adr, 0);
        check("wr_keeps_rdata", rdata, 32'hDEAD_BEEF);

        // Back-to-back: req held high still leaves one IDLE cycle with breq_=1.
        req = 1'b1; req_we = 1'b1; req_adr = 32'h100; req_wdata = 32'h1;
        step();
        step();
        req_adr = 32'h104;
        check("b2b_first_adr", adr, 32'h100);
        step();
        step();
        check("b2b_gap", W'({breq_, busy}), 'h2);
        step();
        check("b2b_second_req", W'(breq_), 0);
        req = 1'b0;
        step();
        check("b2b_second_adr", adr, 32'h104);
        step(); step();

        // Grant withheld 10 cycles; a new req during the wait is ignored.
        bgrt_ = 1'b1;
        issue(1'b1, 32'h33, 32'hA5);
        req = 1'b1; req_adr = 32'h77; req_wdata = 32'h77;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (breq_ !== 1'b0 || own !== 1'b0 || busy !== 1'b1) bad++;
            step();
        end
        check("wait10_bad_cycles", W'(bad), 0);
        check("wait10_no_err", W'({err, req_ack}), 0);
        req = 1'b0;
        bgrt_ = 1'b0;
        step();
        check("wait10_xfer_adr", adr, 32'h33);
        check("wait10_xfer_idata", idata, 32'hA5);
        run_acks(6, acks, ack_rd);
        check("wait10_one_ack", W'(acks), 1);

        // Grant lost in WAIT: own drops, access retried, one ack with retried data.
        odata = 32'h1111_1111;
        issue(1'b0, 32'h40, 32'd0);
        step();
        step();
        check("lost_wait_bus", W'({own, rw_}), 'h3);
        check("lost_wait_adr", adr, 32'h40);
        bgrt_ = 1'b1;
        step();
        check("lost_dropped", W'({own, breq_, req_ack, busy}), 'h1);
        check("lost_adr_zero", adr, 0);
        check("lost_no_capture", rdata, 32'hDEAD_BEEF);
        odata = 32'hCAFE_F00D;
        bgrt_ = 1'b0;
        run_acks(8, acks, ack_rd);
        check("lost_one_ack", W'(acks), 1);
        check("lost_retry_data", ack_rd, 32'hCAFE_F00D);

        // Reset during WAIT discards the access; a fresh read then completes.
        odata = 32'h5555_AAAA;
        issue(1'b0, 32'h80, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("wait_reset");
        reset = 1'b0;
        run_acks(4, acks, ack_rd);
        check("wait_reset_no_ack", W'(acks), 0);
        odata = 32'h1234_5678;
        issue(1'b0, 32'h84, 32'd0);
        run_acks(8, acks, ack_rd);
        check("fresh_read_ack", W'(acks), 1);
        check("fresh_read_data", ack_rd, 32'h1234_5678);

`ifdef BUSMST_TIMEOUT_EN
        // Grant never given: ack+err 64 cycles after entering REQ, no done.
        bgrt_ = 1'b1;
        issue(1'b1, 32'h9, 32'h9);
        lat = 0;
        while (req_ack !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        check("tmo_cycles", W'(lat), 64);
        check("tmo_flags", W'({err, done, breq_}), 'h5);
        step();
        check("tmo_pulse_end", W'({req_ack, err, breq_}), 'h1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
- REQ-001: Parameter WIDTH, default 32: data and address width.
- REQ-002: Parameter MEM_LAT, default 1: cycles from read command to valid odata (1..15).
- REQ-003: Parameter TIMEOUT, default 64: grant-wait limit in cycles; used only with BUSMST_TIMEOUT_EN.
- REQ-004: clk  in  1  single clock; all state updates on rising edge.
- REQ-005: reset  in  1  synchronous, active-high reset.
- REQ-006: req  in  1  core access request, sampled in IDLE only.
- REQ-007: req_we  in  1  1=store, 0=load.
- REQ-008: req_adr  in  WIDTH  access address.
- REQ-009: req_wdata  in  WIDTH  store data.
- REQ-010: req_ack  out  1  one-cycle completion pulse.
- REQ-011: rdata  out  WIDTH  load result, valid when req_ack=1 and req_we was 0.
- REQ-012: busy  out  1  high in every state except IDLE.
- REQ-013: err  out  1  grant timeout flag, valid with req_ack.
- REQ-014: breq_  out  1  active-low bus request to the arbiter.
- REQ-015: bgrt_  in  1  active-low bus grant from the arbiter.
- REQ-016: own  out  1  high while the block drives adr/rw_/idata; the top-level mux selects on it.
- REQ-017: adr  out  WIDTH  bus address; 0 when own=0.
- REQ-018: rw_  out  1  1=Read, 0=Write; 1 when own=0.
- REQ-019: idata  out  WIDTH  bus write data; 0 when own=0.
- REQ-020: odata  in  WIDTH  bus read data.
- REQ-021: done  out  1  one-cycle end-of-tenure pulse to the arbiter.

Function
- REQ-022: FSM states: IDLE, REQ, XFER, WAIT, DONE.
- REQ-023: IDLE: breq_=1, own=0. If req=1, latch req_adr, req_we and req_wdata, then go to REQ.
- REQ-024: REQ: breq_=0. If bgrt_=0 is sampled, go to XFER; otherwise stay.
- REQ-025: XFER (1 cycle): own=1; adr is the latched address; rw_=~we; idata is the latched data for a write, 0 for a read. A write goes to DONE; a read goes to WAIT with a counter loaded to MEM_LAT-1.
- REQ-026: WAIT: own=1 with the same adr and rw_=1. The counter decrements each cycle. When the counter is 0, capture odata into rdata and go to DONE.
- REQ-027: DONE (1 cycle): done=1, req_ack=1, breq_=0, own=1, then go to IDLE.
- REQ-028: Write latency from the first granted cycle: XFER then DONE, 2 cycles. Read latency: 2+MEM_LAT cycles.
- REQ-029: breq_ stays high for at least one IDLE cycle between tenures, so back-to-back requests let the arbiter re-arbitrate.
- REQ-030: req asserted while busy=1 is ignored and not queued; latched operands do not change during a tenure.
- REQ-031: If bgrt_=1 is sampled in XFER or WAIT (grant lost): drop own the next cycle, return to REQ, and retry the whole access. No req_ack is issued for the aborted attempt.
- REQ-032: rdata holds its last value until the next read capture; a write does not alter rdata.
- REQ-033: All outputs are registered except adr, rw_ and idata, which are decoded from state and latched operands.

Reset
- REQ-034: reset=1 at a rising edge forces IDLE from any state, including mid-tenure.
- REQ-035: Output values under reset: breq_=1, own=0, done=0, req_ack=0, busy=0, err=0, rdata=0, adr=0, rw_=1, idata=0.
- REQ-036: A request pending when reset asserts is discarded.

Configuration
- REQ-037: Macro BUSMST_TIMEOUT_EN defined: a counter runs in REQ. After TIMEOUT cycles without a grant, go to IDLE with breq_=1 and pulse req_ack=1 and err=1 for one cycle. done is not pulsed. The counter clears on every entry to REQ.
- REQ-038: Macro BUSMST_TIMEOUT_EN undefined: there is no counter, err is tied to 0, and REQ waits for a grant indefinitely.

Verification
- REQ-039: Write 0x0000_0014 to adr 5, grant held low → bus shows rw_=0, adr=5, idata=20 for one cycle. The next cycle shows done=1 and req_ack=1. breq_=1 follows.
- REQ-040: Read adr 8, MEM_LAT=1, odata=0xDEAD_BEEF → req_ack exactly 3 cycles after the first bgrt_=0 sample, with rdata=0xDEAD_BEEF.
- REQ-041: Grant withheld 10 cycles → breq_=0 and own=0 for those 10 cycles, then a normal transfer with exactly one req_ack.
- REQ-042: bgrt_ raised in WAIT → own=0 the next cycle and the access re-requested. Exactly one req_ack, carrying the retried read data.
- REQ-043: reset pulsed during WAIT → all outputs at reset values the next cycle and no req_ack. A fresh read then completes normally.
- REQ-044: With BUSMST_TIMEOUT_EN and TIMEOUT=64, grant never given → req_ack=1 and err=1 exactly 64 cycles after entering REQ, done=0, and breq_=1 afterward.
